// File: rtl/mult_div_ctrl.sv
// Iterative multiply/divide unit: 32-cycle shift-add multiply and restoring
// divide, sign fix-up, HI/LO result registers and MTHI/MTLO writes.
module mult_div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [5:0] LAST_ITER = 6'(DATA_W - 1);

  logic [1:0]               state;
  logic [5:0]               cnt;
  logic                     op_div;
  logic                     neg_q;
  logic                     neg_r;
  logic                     div_zero;
  logic [DATA_W-1:0]        b_mag;
  logic [2*DATA_W-1:0]      acc;

  logic signed [DATA_W-1:0] rs_s;
  logic signed [DATA_W-1:0] rt_s;
  logic                     is_md;
  logic                     is_sgn;
  logic                     start_div;
  logic [DATA_W:0]          mul_sum;
  logic [DATA_W:0]          div_shift;
  logic [DATA_W:0]          div_trial;

  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                  input logic sgn);
    logic [DATA_W-1:0] m;
    m = v;
    if (sgn && v < 0) m = -m;
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                   input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] apply_sign_wide(input logic [2*DATA_W-1:0] v,
                                                          input logic neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    rs_s      = rs_val;
    rt_s      = rt_val;
    is_md     = (funct == F_MULT) || (funct == F_MULTU) ||
                (funct == F_DIV)  || (funct == F_DIVU);
    is_sgn    = (funct == F_MULT) || (funct == F_DIV);
    start_div = (funct == F_DIV)  || (funct == F_DIVU);
    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, b_mag};
    div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    div_trial = div_shift - {1'b0, b_mag};
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      b_mag    <= '0;
      acc      <= '0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && is_md) begin
            op_div <= start_div;
            neg_q  <= is_sgn && ((rs_s < 0) != (rt_s < 0));
            neg_r  <= is_sgn && (rs_s < 0);
            cnt    <= '0;
            if (start_div && rt_val == '0) begin
              // divide by zero bypasses the iteration; result is preloaded
              div_zero <= 1'b1;
              acc      <= {rs_val, {DATA_W{1'b1}}};
              state    <= FIX;
            end else begin
              div_zero <= 1'b0;
              state    <= CALC;
              if (start_div) begin
                acc   <= {{DATA_W{1'b0}}, magnitude(rs_s, is_sgn)};
                b_mag <= magnitude(rt_s, is_sgn);
              end else begin
                acc   <= {{DATA_W{1'b0}}, magnitude(rt_s, is_sgn)};
                b_mag <= magnitude(rs_s, is_sgn);
              end
            end
          end else if (start && funct == F_MTHI) begin
            hi   <= rs_val;
            done <= 1'b1;
          end else if (start && funct == F_MTLO) begin
            lo   <= rs_val;
            done <= 1'b1;
          end
        end
        CALC: begin
          if (op_div) begin
            if (!div_trial[DATA_W])
              acc <= {div_trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
            else
              acc <= {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
          end else begin
            if (acc[0])
              acc <= {mul_sum, acc[DATA_W-1:1]};
            else
              acc <= {1'b0, acc[2*DATA_W-1:1]};
          end
          cnt <= cnt + 6'd1;
          if (cnt == LAST_ITER) state <= FIX;
        end
        FIX: begin
          // sign correction of magnitude results, then commit to HI/LO
          state <= IDLE;
          done  <= 1'b1;
          if (div_zero) begin
            hi <= acc[2*DATA_W-1:DATA_W];
            lo <= acc[DATA_W-1:0];
          end else if (op_div) begin
            hi <= apply_sign(acc[2*DATA_W-1:DATA_W], neg_r);
            lo <= apply_sign(acc[DATA_W-1:0], neg_q);
          end else begin
            {hi, lo} <= apply_sign_wide(acc, neg_q);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
